hit_event_queue: RTL and testbench

Consumes the detector's per-window `overall_result` and its `flag` strobe, and turns them into discrete note-onset events: which bar (1–4) was struck and when. A bounce-suppression state machine filters out repeated hits. Each event is stamped with a free-running window counter and buffered in a small first-word-fall-through FIFO. The FIFO is drained by the bus-side register interface using a valid/ready handshake.

---
 rtl/hit_event_queue_pkg.sv | 27 ++
 rtl/hit_event_queue_if.sv | 14 +
 rtl/event_fifo.sv | 48 ++++
 rtl/hit_event_queue.sv | 126 ++++++++++++
 tb/tb_hit_event_queue.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hit_event_queue_pkg.sv
// Shared types and constants for the hit event queue: FSM states, note range
// and the packed event record stored in the FIFO.
package hit_pkg;

    localparam int TS_WIDTH = 24;

    localparam logic [2:0] NOTE_SILENCE = 3'd0;
    localparam logic [2:0] NOTE_MAX     = 3'd4;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        NOTE   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // "time" is a reserved word, so the stamp field is called tstamp.
    typedef struct packed {
        logic [2:0]          note;
        logic [TS_WIDTH-1:0] tstamp;
    } hit_event_t;

    // Results 5-7 are not bars and behave exactly like silence.
    function automatic logic is_note(input logic [2:0] v);
        return (v != NOTE_SILENCE) && (v <= NOTE_MAX);
    endfunction

endpackage

// File: rtl/hit_event_queue_if.sv
// Event output stream of the hit queue. Handshake: the producer holds valid,
// note and time stable until a cycle where valid && ready, which pops the head.
interface hit_event_queue_if;
    import hit_pkg::*;

    logic                out_valid;
    logic                out_ready;
    logic [2:0]          out_note;
    logic [TS_WIDTH-1:0] out_time;

    modport master (output out_valid, output out_note, output out_time, input out_ready);
    modport slave  (input out_valid, input out_note, input out_time, output out_ready);

endinterface

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is always visible on
// head_o while valid_o is high. Pointers carry one extra wrap bit.
module event_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] fill_o,
    output logic                   drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         full, empty, do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // A pop frees the slot this same cycle, so push while full succeeds with a pop.
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !pop_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end

    assign valid_o = !empty;
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign fill_o  = wr_q - rd_q;

endmodule

// File: rtl/hit_event_queue.sv
// Turns per-window detector results into de-bounced note-onset events, stamps
// them with a window counter and queues them for the bus side.
module hit_event_queue
    import hit_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = hit_pkg::TS_WIDTH,  // must equal the package value
    parameter int HOLDOFF  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flag,
    input  logic [2:0]             overall_result,
    hit_event_queue_if.master      out_if,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output state_t                 dbg_state_o
);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    state_t              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [2:0]          last_q, last_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                overflow_q, overflow_d;
    logic                push, drop, fifo_valid;
    hit_event_t          push_ev, head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SILENT;
            ts_q       <= '0;
            last_q     <= NOTE_SILENCE;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

    // hold_q counts the silent flags still needed; the flag that leaves NOTE
    // is itself the first of the HOLDOFF silent ticks.
    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        last_d  = last_q;
        hold_d  = hold_q;
        push    = 1'b0;
        if (flag) begin
            ts_d = ts_q + 1'b1;
            case (state_q)
                SILENT: begin
                    if (is_note(overall_result)) begin
                        push    = 1'b1;
                        last_d  = overall_result;
                        state_d = NOTE;
                    end
                end
                NOTE: begin
                    if (!is_note(overall_result)) begin
                        if (HOLDOFF <= 1) begin
                            hold_d  = '0;
                            state_d = SILENT;
                        end else begin
                            hold_d  = HW'(HOLDOFF - 1);
                            state_d = HOLD;
                        end
                    end else if (overall_result != last_q) begin
                        push   = 1'b1;
                        last_d = overall_result;
                    end
                end
                HOLD: begin
                    if (!is_note(overall_result)) begin
                        hold_d = hold_q - 1'b1;
                        if (hold_q <= 1) state_d = SILENT;
                    end else if (overall_result == last_q) begin
                        state_d = NOTE;
                    end else begin
                        push    = 1'b1;
                        last_d  = overall_result;
                        state_d = NOTE;
                    end
                end
                default: state_d = SILENT;
            endcase
        end
    end

    assign push_ev.note   = overall_result;
    assign push_ev.tstamp = ts_q;

    // A drop in the same cycle as a clear wins, so no drop goes unreported.
    always_comb begin
        overflow_d = overflow_q;
        if (drop)                overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(hit_event_t))
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_ev),
        .pop_i       (out_if.out_ready),
        .valid_o     (fifo_valid),
        .head_o      (head),
        .fill_o      (fill),
        .drop_o      (drop)
    );

    assign out_if.out_valid = fifo_valid;
    assign out_if.out_note  = head.note;
    assign out_if.out_time  = head.tstamp;
    assign overflow         = overflow_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_hit_event_queue.sv
// Directed bench for hit_event_queue: onset detection, bounce filtering,
// FIFO full/overflow behaviour, timestamp wrap and asynchronous reset.
module tb_hit_event_queue;
    import hit_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flag = 1'b0;
    logic       clear_overflow = 1'b0;
    logic [2:0] overall_result = 3'd0;
    logic [4:0] fill;
    logic       overflow;
    state_t     dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [26:0] exp_q[$];

    hit_event_queue_if bus();

    always #5 clk = ~clk;

    hit_event_queue #(
        .DEPTH    (16),
        .TS_WIDTH (24),
        .HOLDOFF  (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flag           (flag),
        .overall_result (overall_result),
        .out_if         (bus),
        .fill           (fill),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One flag cycle; returns at the negedge right after the sampling posedge.
    task automatic do_flag(input logic [2:0] r);
        @(negedge clk);
        flag           = 1'b1;
        overall_result = r;
        @(negedge clk);
        flag           = 1'b0;
        overall_result = 3'd0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.out_valid); end
        checks++; if (fill !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
        checks++; if (bus.out_note !== 3'd0) begin failures++; $display("FAIL reset_note got=%0h exp=0", bus.out_note); end
        checks++; if (bus.out_time !== 24'd0) begin failures++; $display("FAIL reset_time got=%0h exp=0", bus.out_time); end
        checks++; if (dbg_state !== SILENT) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, SILENT); end
        reset = 1'b0;
    endtask

    task automatic test_single_onset();
        apply_reset();
        do_flag(3'd0); idle(3);
        do_flag(3'd0); idle(3);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL onset_pre_valid got=%0h exp=0", bus.out_valid); end
        do_flag(3'd2);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL onset_valid_latency got=%0h exp=1", bus.out_valid); end
        checks++; if (fill !== 5'd1) begin failures++; $display("FAIL onset_fill_latency got=%0d exp=1", fill); end
        idle(3); do_flag(3'd2);
        idle(3); do_flag(3'd2);
        idle(3); do_flag(3'd0);
        checks++; if (fill !== 5'd1) begin failures++; $display("FAIL onset_count got=%0d exp=1", fill); end
        checks++; if (bus.out_note !== 3'd2 || bus.out_time !== 24'd2) begin failures++; $display("FAIL onset_event got=%0h/%0h exp=2/2", bus.out_note, bus.out_time); end
        pop_one();
        checks++; if (bus.out_valid !== 1'b0 || fill !== 5'd0) begin failures++; $display("FAIL onset_pop got=%0h/%0d exp=0/0", bus.out_valid, fill); end
    endtask

    task automatic test_bounce();
        logic [2:0] seq [4];
        seq = '{3'd3, 3'd0, 3'd0, 3'd3};
        apply_reset();
        for (int i = 0; i < 4; i++) begin do_flag(seq[i]); idle(2); end
        checks++; if (fill !== 5'd1) begin failures++; $display("FAIL bounce_fill got=%0d exp=1", fill); end
        checks++; if (dbg_state !== NOTE) begin failures++; $display("FAIL bounce_state got=%0d exp=%0d", dbg_state, NOTE); end
        for (int i = 0; i < 6; i++) begin do_flag(3'd0); idle(2); end
        checks++; if (dbg_state !== SILENT) begin failures++; $display("FAIL holdoff_state got=%0d exp=%0d", dbg_state, SILENT); end
        do_flag(3'd3);
        checks++; if (fill !== 5'd2) begin failures++; $display("FAIL retrigger_fill got=%0d exp=2", fill); end
        checks++; if (bus.out_note !== 3'd3 || bus.out_time !== 24'd0) begin failures++; $display("FAIL bounce_first got=%0h/%0h exp=3/0", bus.out_note, bus.out_time); end
        pop_one();
        checks++; if (bus.out_note !== 3'd3 || bus.out_time !== 24'd10) begin failures++; $display("FAIL retrigger_event got=%0h/%0h exp=3/a", bus.out_note, bus.out_time); end
        pop_one();
    endtask

    task automatic test_note_change();
        apply_reset();
        do_flag(3'd1);
        do_flag(3'd4);
        checks++; if (fill !== 5'd2) begin failures++; $display("FAIL change_fill got=%0d exp=2", fill); end
        checks++; if (bus.out_note !== 3'd1 || bus.out_time !== 24'd0) begin failures++; $display("FAIL change_first got=%0h/%0h exp=1/0", bus.out_note, bus.out_time); end
        pop_one();
        checks++; if (bus.out_note !== 3'd4 || bus.out_time !== 24'd1) begin failures++; $display("FAIL change_second got=%0h/%0h exp=4/1", bus.out_note, bus.out_time); end
        pop_one();
        apply_reset();
        do_flag(3'd7);
        checks++; if (fill !== 5'd0) begin failures++; $display("FAIL result7_silence got=%0d exp=0", fill); end
        do_flag(3'd1);
        do_flag(3'd0);
        do_flag(3'd4);
        checks++; if (fill !== 5'd2) begin failures++; $display("FAIL hold_change_fill got=%0d exp=2", fill); end
        pop_one();
        checks++; if (bus.out_note !== 3'd4 || bus.out_time !== 24'd3) begin failures++; $display("FAIL hold_change_event got=%0h/%0h exp=4/3", bus.out_note, bus.out_time); end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [2:0] n;
        apply_reset();
        bus.out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            n = (i % 2 == 0) ? 3'd1 : 3'd2;
            if (i < 16) exp_q.push_back({n, 24'(i)});
            if (i == 16) begin
                checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_early got=%0h exp=0", overflow); end
            end
            do_flag(n);
        end
        checks++; if (fill !== 5'd16) begin failures++; $display("FAIL full_fill got=%0d exp=16", fill); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%0h exp=1", overflow); end
        checks++; if (bus.out_note !== 3'd1 || bus.out_time !== 24'd0) begin failures++; $display("FAIL full_head got=%0h/%0h exp=1/0", bus.out_note, bus.out_time); end
        @(negedge clk); clear_overflow = 1'b1;
        @(negedge clk); clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%0h exp=0", overflow); end
        // Push and pop together while full: ts is 17 here.
        @(negedge clk);
        bus.out_ready = 1'b1; flag = 1'b1; overall_result = 3'd2;
        @(negedge clk);
        bus.out_ready = 1'b0; flag = 1'b0; overall_result = 3'd0;
        void'(exp_q.pop_front());
        exp_q.push_back({3'd2, 24'd17});
        checks++; if (fill !== 5'd16) begin failures++; $display("FAIL push_pop_full got=%0d exp=16", fill); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL push_pop_no_drop got=%0h exp=0", overflow); end
        // Clear in the same cycle as a fresh drop.
        @(negedge clk);
        clear_overflow = 1'b1; flag = 1'b1; overall_result = 3'd1;
        @(negedge clk);
        clear_overflow = 1'b0; flag = 1'b0; overall_result = 3'd0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clear_vs_drop got=%0h exp=1", overflow); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_note, bus.out_time} !== exp_q[0]) begin
                failures++;
                $display("FAIL drain_%0d got=%0h/%0h exp=%0h", i, bus.out_note, bus.out_time, exp_q[0]);
            end
            void'(exp_q.pop_front());
            pop_one();
        end
        checks++; if (bus.out_valid !== 1'b0 || fill !== 5'd0) begin failures++; $display("FAIL drain_empty got=%0h/%0d exp=0/0", bus.out_valid, fill); end
    endtask

    task automatic test_ts_wrap();
        apply_reset();
        @(negedge clk);
        force dut.ts_q = 24'hFFFFFF;
        #1 release dut.ts_q;
        do_flag(3'd1);
        do_flag(3'd2);
        checks++; if (fill !== 5'd2) begin failures++; $display("FAIL wrap_fill got=%0d exp=2", fill); end
        checks++; if (bus.out_note !== 3'd1 || bus.out_time !== 24'hFFFFFF) begin failures++; $display("FAIL wrap_max got=%0h/%0h exp=1/ffffff", bus.out_note, bus.out_time); end
        pop_one();
        checks++; if (bus.out_note !== 3'd2 || bus.out_time !== 24'd0) begin failures++; $display("FAIL wrap_zero got=%0h/%0h exp=2/0", bus.out_note, bus.out_time); end
        pop_one();
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) do_flag((i % 2 == 0) ? 3'd3 : 3'd4);
        checks++; if (fill !== 5'd5) begin failures++; $display("FAIL pre_reset_fill got=%0d exp=5", fill); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || fill !== 5'd0) begin failures++; $display("FAIL async_reset_fifo got=%0h/%0d exp=0/0", bus.out_valid, fill); end
        checks++; if (dbg_state !== SILENT) begin failures++; $display("FAIL async_reset_state got=%0d exp=%0d", dbg_state, SILENT); end
        @(negedge clk);
        reset = 1'b0;
        do_flag(3'd4);
        checks++; if (bus.out_note !== 3'd4 || bus.out_time !== 24'd0 || fill !== 5'd1) begin failures++; $display("FAIL restart_event got=%0h/%0h/%0d exp=4/0/1", bus.out_note, bus.out_time, fill); end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_single_onset();
        test_bounce();
        test_note_change();
        test_overflow();
        test_ts_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
